// File: rtl/psum_accumulator.sv
// psum_accumulator
//
// Lane-wise partial-sum accumulator placed directly after the
// hybrid-precision multiplier in the PE datapath. A start pulse latches
// the accumulation length and the ifmap quantization size. Products are
// then taken one per cycle over a valid/ready handshake. The finished
// packed partial sum is offered over a second valid/ready handshake.
//
// Lane layout by quantization size:
//   8 -> one lane of PSUM_BITS bits
//   4 -> two lanes of PSUM_BITS/2 bits
//   2 -> four lanes of PSUM_BITS/4 bits
// Each lane wraps independently, so no carry crosses a lane boundary.
// Any other size adds nothing, which leaves the cleared accumulator at 0.
//
// Ports:
//   clk        : clock; all state updates on its rising edge
//   rst        : synchronous active-high reset
//   start      : begin an accumulation (honoured only when idle)
//   acc_len    : number of products to accumulate, sampled with start
//   quant_size : ifmap quantization size (2, 4 or 8), sampled with start
//   in_valid   : product is present on product
//   in_ready   : accumulator accepts a product this cycle
//   product    : packed product from the multiplier
//   out_valid  : psum holds a finished result
//   out_ready  : consumer takes psum this cycle
//   psum       : packed accumulated partial sum
//   busy       : block is not idle

module psum_accumulator #(
    parameter int PSUM_BITS = 24,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  acc_len,
    input  logic [3:0]           quant_size,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PSUM_BITS-1:0] product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PSUM_BITS-1:0] psum,
    output logic                 busy
);

    localparam int HALF    = PSUM_BITS / 2;
    localparam int QUARTER = PSUM_BITS / 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [PSUM_BITS-1:0] acc;
    logic [LEN_BITS-1:0]  count;
    logic [LEN_BITS-1:0]  len_q;
    logic [3:0]           quant_q;

    logic [PSUM_BITS-1:0] sum_q8;
    logic [PSUM_BITS-1:0] sum_q4;
    logic [PSUM_BITS-1:0] sum_q2;
    logic [PSUM_BITS-1:0] acc_next;
    logic                 last_product;

    // Lane sums for every quantization size are built side by side; each
    // addition is sized to its lane so the carry out of a lane is dropped.
    always_comb begin
        sum_q8 = acc + product;
        sum_q4 = {acc[PSUM_BITS-1:HALF] + product[PSUM_BITS-1:HALF],
                  acc[HALF-1:0] + product[HALF-1:0]};
        sum_q2 = '0;
        for (int k = 0; k < 4; k++) begin
            sum_q2[k*QUARTER +: QUARTER] = acc[k*QUARTER +: QUARTER]
                                         + product[k*QUARTER +: QUARTER];
        end
        case (quant_q)
            4'd8:    acc_next = sum_q8;
            4'd4:    acc_next = sum_q4;
            4'd2:    acc_next = sum_q2;
            default: acc_next = acc;
        endcase
    end

    // The accepted product is the final one when the running count has
    // reached acc_len-1; written as count+1 to avoid an underflowing
    // subtraction on the latched length.
    assign last_product = ((count + 1'b1) == len_q);

    // Control and datapath state. The accumulator and counter are cleared
    // on start so a run never inherits the previous result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            len_q   <= '0;
            quant_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= acc_len;
                        quant_q <= quant_size;
                        acc     <= '0;
                        count   <= '0;
                        state   <= (acc_len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (last_product) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode only registered state, so neither in_valid
    // nor out_ready reaches in_ready/out_valid combinationally.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign psum      = acc;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
//
// Scoreboard bench for psum_accumulator. The stimulus process pushes the
// expected psum of each run into a queue when it issues the start; a
// monitor pops and compares whenever the DUT completes an output
// handshake. Random runs use a lane-by-lane arithmetic reference model.

module tb_psum_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  acc_len;
    logic [3:0]  quant_size;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] psum;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [23:0] sb[$];
    logic [23:0] txn_products[$];
    bit          gap_pat[$];
    bit          hold_ready;

    logic        prev_stall;
    logic [23:0] prev_psum;

    psum_accumulator #(.PSUM_BITS(24), .LEN_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .acc_len    (acc_len),
        .quant_size (quant_size),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .product    (product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .psum       (psum),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: split each product into lanes of 24/lanes bits,
    // sum each lane as a plain integer and keep it modulo 2^width.
    function automatic logic [23:0] model(input logic [3:0] q, input int len);
        int     lanes;
        int     w;
        longint mask;
        longint s;
        longint res;
        case (q)
            4'd8:    lanes = 1;
            4'd4:    lanes = 2;
            4'd2:    lanes = 4;
            default: lanes = 0;
        endcase
        if (lanes == 0) return 24'd0;
        w    = 24 / lanes;
        mask = (longint'(1) << w) - 1;
        res  = 0;
        for (int k = 0; k < lanes; k++) begin
            s = 0;
            for (int i = 0; i < len; i++) begin
                s += (longint'(txn_products[i]) >> (k * w)) & mask;
            end
            res |= (s & mask) << (k * w);
        end
        return res[23:0];
    endfunction

    // Consumer readiness: random unless the stimulus takes control.
    always @(posedge clk) begin
        #1;
        if (!hold_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: on every output handshake pop the oldest expected psum;
    // while the consumer stalls, psum must not move.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && prev_stall) checkOutput("psum_stable", psum, prev_psum);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual=%0h required=none", psum);
                end else begin
                    checkOutput("psum", psum, sb.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_psum  = psum;
        end
    end

    // Issue one run. restart_at injects a stray start alongside that
    // product; abort_after stops feeding after that many products and
    // pushes no expectation (the run is killed by reset).
    task automatic applyStimulus(input int len, input logic [3:0] q,
                                 input logic [23:0] expected,
                                 input int restart_at, input int abort_after);
        int idx    = 0;
        int slot   = 0;
        int budget = 0;
        bit took;
        acc_len    = 8'(len);
        quant_size = q;
        start      = 1'b1;
        if (abort_after < 0) sb.push_back(expected);
        tick();
        start      = 1'b0;
        acc_len    = 8'($urandom);
        quant_size = 4'($urandom);
        checkOutput("busy_after_start", busy, 1);
        if (len == 0) begin
            checkOutput("len0_out_valid", out_valid, 1);
            checkOutput("len0_in_ready", in_ready, 0);
            return;
        end
        checkOutput("in_ready_after_start", in_ready, 1);
        while (idx < len && budget < 500) begin
            if (abort_after >= 0 && idx == abort_after) begin
                in_valid = 1'b0;
                return;
            end
            checkOutput("in_ready_acc", in_ready, 1);
            if (slot < gap_pat.size()) took = gap_pat[slot];
            else took = ($urandom_range(0, 3) != 0);
            in_valid = took;
            product  = took ? txn_products[idx] : 24'($urandom);
            if (took && idx == restart_at) begin
                start      = 1'b1;
                acc_len    = 8'd1;
                quant_size = 4'd4;
            end
            tick();
            start = 1'b0;
            if (took) idx++;
            slot++;
            budget++;
        end
        in_valid = 1'b0;
        product  = 24'($urandom);
        checkOutput("feed_budget", (idx == len), 1);
        checkOutput("out_valid_latency", out_valid, 1);
        checkOutput("in_ready_done", in_ready, 0);
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (busy && budget < 200) begin
            tick();
            budget++;
        end
        checkOutput("returns_idle", busy, 0);
    endtask

    initial begin
        logic [23:0] held;
        logic [23:0] exp_v;
        int          len;
        logic [3:0]  q;
        rst        = 1'b1;
        start      = 1'b0;
        acc_len    = '0;
        quant_size = '0;
        in_valid   = 1'b0;
        product    = '0;
        out_ready  = 1'b0;
        hold_ready = 1'b0;
        prev_stall = 1'b0;
        prev_psum  = '0;
        tick();
        tick();
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_psum", psum, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        $display("[TB] 8-bit accumulation");
        txn_products = '{24'd10, 24'hFFFFFB, 24'd7};
        gap_pat = '{1, 1, 1};
        applyStimulus(3, 4'd8, 24'd12, -1, -1);
        gap_pat = {};
        waitIdle();

        $display("[TB] 4-bit lane isolation");
        txn_products = '{{12'h7FF, 12'h001}, {12'h001, 12'hFFF}};
        applyStimulus(2, 4'd4, 24'h800000, -1, -1);
        waitIdle();

        $display("[TB] 2-bit lane wrap");
        txn_products = '{{4{6'h3F}}, {4{6'h01}}};
        applyStimulus(2, 4'd2, 24'h000000, -1, -1);
        waitIdle();

        $display("[TB] bubbles and backpressure");
        hold_ready = 1'b1;
        out_ready  = 1'b0;
        txn_products = {};
        for (int i = 0; i < 4; i++) txn_products.push_back(24'($urandom));
        gap_pat = '{1, 0, 1, 0, 1, 1};
        applyStimulus(4, 4'd8, model(4'd8, 4), -1, -1);
        gap_pat = {};
        held = psum;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_psum", psum, held);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("idle_after_ready_busy", busy, 0);
        checkOutput("idle_after_ready_valid", out_valid, 0);
        out_ready  = 1'b0;
        hold_ready = 1'b0;

        $display("[TB] edge configurations");
        applyStimulus(0, 4'd8, 24'd0, -1, -1);
        waitIdle();
        txn_products = '{24'h123456, 24'hABCDEF};
        applyStimulus(2, 4'd5, 24'd0, -1, -1);
        waitIdle();

        $display("[TB] ignored start");
        txn_products = {};
        for (int i = 0; i < 4; i++) txn_products.push_back(24'($urandom));
        applyStimulus(4, 4'd8, model(4'd8, 4), 1, -1);
        waitIdle();

        $display("[TB] reset mid-run");
        txn_products = {};
        for (int i = 0; i < 4; i++) txn_products.push_back(24'($urandom));
        applyStimulus(4, 4'd2, 24'd0, -1, 2);
        rst = 1'b1;
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_psum", psum, 0);
        rst = 1'b0;
        tick();
        txn_products = {};
        for (int i = 0; i < 3; i++) txn_products.push_back(24'($urandom));
        applyStimulus(3, 4'd2, model(4'd2, 3), -1, -1);
        waitIdle();

        $display("[TB] random runs");
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0:       q = 4'd8;
                1:       q = 4'd4;
                2:       q = 4'd2;
                default: q = 4'($urandom_range(9, 15));
            endcase
            len = $urandom_range(0, 10);
            txn_products = {};
            for (int i = 0; i < len; i++) txn_products.push_back(24'($urandom));
            exp_v = model(q, len);
            applyStimulus(len, q, exp_v, -1, -1);
            waitIdle();
            in_valid = 1'b1;
            product  = 24'($urandom);
            tick();
            in_valid = 1'b0;
            checkOutput("idle_ignores_in_valid", busy, 0);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
